// File: rtl/sik_mem_responder_pkg.sv
// Shared types and constants for the SIK data-memory responder.
// Slot states, response bundle and latency bounds.
package sik_mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 15;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic                  thread;
        logic                  write;
        logic [DEF_DATA_W-1:0] data;
    } rsp_t;

    function automatic bit lat_ok(int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/sik_mem_responder_if.sv
// Request/response channel between the write-back stage and the
// data-memory responder, plus the per-thread pending flags.
interface sik_mem_responder_if
    import sik_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_thread;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_thread;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        pending;

    modport master (
        output req_valid, req_write, req_thread,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_thread,
        input  rsp_write, rsp_rdata, pending
    );

    modport slave (
        input  req_valid, req_write, req_thread,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_thread,
        output rsp_write, rsp_rdata, pending
    );
endinterface

// File: rtl/sik_mem_responder_slot.sv
// One per-thread request slot: state, latency countdown and the
// captured response payload.
module sik_mem_slot
    import sik_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic              retire,
    output slot_state_e       state,
    output logic              due,
    output logic              wr,
    output logic [DATA_W-1:0] data
);
    slot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wr_d    = wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    data_d  = data_in;
                    wr_d    = write;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                if (retire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // due also covers the edge on which the slot enters S_DONE, so the
    // output register can load it without an extra cycle of latency
    assign due   = (state_q == S_DONE) ||
                   ((state_q == S_WAIT) && (cnt_q == '0));
    assign state = state_q;
    assign wr    = wr_q;
    assign data  = data_q;
endmodule

// File: rtl/sik_mem_responder.sv
// Two-thread data-memory responder: 2 x 2^ADDR_W word memory, one
// request slot per thread, fixed-latency responses over valid/ready.
module sik_mem_responder
    import sik_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LATENCY = 4
) (
    input  logic                clk,
    input  logic                reset,
    sik_mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_W + 1);

    generate
        if (!lat_ok(LATENCY)) begin : g_bad_latency
            $error("sik_mem_responder: LATENCY out of range");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    slot_state_e       st [2];
    logic [DATA_W-1:0] sdata [2];
    logic [1:0]        due;
    logic [1:0]        swr;
    logic [1:0]        accept;
    logic [1:0]        retire;
    logic [1:0]        avail;

    logic [ADDR_W:0]   idx;
    logic [DATA_W-1:0] cap;
    logic              thr;
    logic              other;
    logic              take;
    logic              hs;
    logic              load;
    logic              pick;
    logic              older;

    logic              rsp_valid_q;
    logic              rsp_thread_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_data_q;

    assign thr   = bus.req_thread;
    assign other = ~bus.req_thread;
    assign idx   = {thr, bus.req_addr};

    // load data is the pre-edge memory content; stores echo wdata
    assign cap   = bus.req_write ? bus.req_wdata : mem[idx];

    assign bus.req_ready = (st[thr] == S_IDLE);
    assign take   = bus.req_valid && bus.req_ready && reset;
    assign accept = {take && thr, take && !thr};

    assign hs     = rsp_valid_q && bus.rsp_ready;
    assign retire = {hs && rsp_thread_q, hs && !rsp_thread_q};
    assign load   = !rsp_valid_q || hs;

    always_ff @(posedge clk) begin
        if (take && bus.req_write) mem[idx] <= bus.req_wdata;
    end

    genvar t;
    generate
        for (t = 0; t < 2; t++) begin : g_slot
            sik_mem_slot #(
                .DATA_W  (DATA_W),
                .LATENCY (LATENCY)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .accept  (accept[t]),
                .write   (bus.req_write),
                .data_in (cap),
                .retire  (retire[t]),
                .state   (st[t]),
                .due     (due[t]),
                .wr      (swr[t]),
                .data    (sdata[t])
            );
        end
    endgenerate

    always_comb begin
        avail = due;
        if (rsp_valid_q) avail[rsp_thread_q] = 1'b0;
        if (&avail) pick = older;
        else        pick = avail[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_thread_q <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_data_q   <= '0;
            older        <= 1'b0;
        end else begin
            if (load) begin
                rsp_valid_q <= |avail;
                if (|avail) begin
                    rsp_thread_q <= pick;
                    rsp_write_q  <= swr[pick];
                    rsp_data_q   <= sdata[pick];
                end
            end
            if (take) older <= (st[other] != S_IDLE) ? other : thr;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_thread = rsp_thread_q;
    assign bus.rsp_write  = rsp_write_q;
    assign bus.rsp_rdata  = rsp_data_q;
    assign bus.pending    = {st[1] != S_IDLE, st[0] != S_IDLE};
endmodule

// File: tb/tb_sik_mem_responder.sv
// Bench for sik_mem_responder: directed scenarios plus random traffic
// against a transaction-level model of slots, latency and memory.
module tb_sik_mem_responder;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sik_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) b ();

    sik_mem_responder #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          out [2];
    int          acc_cyc [2];
    bit          exp_wr [2];
    bit          known [2];
    logic [15:0] exp_data [2];
    logic [15:0] mem_m [int];
    int          last_acc_cyc = -1;
    int          last_hs_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit w, input bit t,
                         input logic [15:0] a, input logic [15:0] d);
        b.req_valid  = v;
        b.req_write  = w;
        b.req_thread = t;
        b.req_addr   = a;
        b.req_wdata  = d;
    endtask

    task automatic check_outputs(input bit hold, input logic [17:0] f);
        bit t;
        bit u;
        bit ot;
        bit overdue;
        chk("pending", 32'(b.pending), 32'({out[1], out[0]}));
        if (b.rsp_valid === 1'b1) begin
            t = b.rsp_thread;
            u = ~t;
            chk("rsp_owner", 32'(out[t]), 32'd1);
            chk("rsp_write", 32'(b.rsp_write), 32'(exp_wr[t]));
            if (known[t])
                chk("rsp_rdata", 32'(b.rsp_rdata), 32'(exp_data[t]));
            chk("rsp_early", 32'(cyc >= acc_cyc[t] + LAT), 32'd1);
            if (hold) begin
                chk("rsp_stable",
                    32'({b.rsp_thread, b.rsp_write, b.rsp_rdata}),
                    32'(f));
            end else begin
                ot = t;
                if (out[u] && cyc >= acc_cyc[u] + LAT &&
                    acc_cyc[u] < acc_cyc[t])
                    ot = u;
                chk("rsp_order", 32'(t), 32'(ot));
            end
        end else begin
            overdue = 1'b0;
            for (int i = 0; i < 2; i++)
                if (out[i] && cyc >= acc_cyc[i] + LAT) overdue = 1'b1;
            chk("rsp_late", 32'(overdue), 32'd0);
        end
    endtask

    task automatic tick();
        bit          acc;
        bit          hs;
        bit          hold;
        bit          t;
        bit          ht;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [17:0] f;
        int          key;
        #1;
        t = b.req_thread;
        chk("req_ready", 32'(b.req_ready), 32'(!out[t]));
        acc  = b.req_valid && !out[t] && reset;
        w    = b.req_write;
        a    = b.req_addr;
        d    = b.req_wdata;
        hs   = (b.rsp_valid === 1'b1) && b.rsp_ready;
        ht   = b.rsp_thread;
        hold = (b.rsp_valid === 1'b1) && !b.rsp_ready;
        f    = {b.rsp_thread, b.rsp_write, b.rsp_rdata};
        @(posedge clk);
        cyc++;
        if (hs) begin
            out[ht] = 1'b0;
            last_hs_cyc = cyc;
        end
        if (acc) begin
            key = 32'({t, a});
            out[t]     = 1'b1;
            acc_cyc[t] = cyc;
            exp_wr[t]  = w;
            if (w) begin
                exp_data[t] = d;
                known[t]    = 1'b1;
                mem_m[key]  = d;
            end else begin
                known[t] = mem_m.exists(key);
                exp_data[t] = known[t] ? mem_m[key] : 16'h0;
            end
            last_acc_cyc = cyc;
        end
        #1;
        check_outputs(hold && reset, f);
    endtask

    task automatic wait_rsp(input bit t, input string tag, output int at);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            if (b.rsp_valid === 1'b1 && b.rsp_thread == t) at = cyc;
            else tick();
        end
        chk({tag, "_seen"}, 32'(at >= 0), 32'd1);
    endtask

    task automatic do_req(input bit w, input bit t, input logic [15:0] a,
                          input logic [15:0] d, input string tag,
                          output logic [15:0] rd, output int lat);
        int n;
        int at;
        drive(1'b1, w, t, a, d);
        tick();
        n = cyc;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_rsp(t, tag, at);
        rd  = b.rsp_rdata;
        lat = at - n;
        chk({tag, "_wr"}, 32'(b.rsp_write), 32'(w));
        tick();
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        int          n;
        int          at;
        int          first;

        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        b.rsp_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(b.rsp_valid), 32'd0);
        chk("rst_thread", 32'(b.rsp_thread), 32'd0);
        chk("rst_write", 32'(b.rsp_write), 32'd0);
        chk("rst_rdata", 32'(b.rsp_rdata), 32'd0);
        chk("rst_pending", 32'(b.pending), 32'd0);
        chk("rst_ready", 32'(b.req_ready), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, "st0", rd, lat);
        chk("st0_lat", 32'(lat), 32'(LAT));
        chk("st0_data", 32'(rd), 32'hBEEF);
        do_req(1'b0, 1'b0, 16'h0010, 16'h0, "ld0", rd, lat);
        chk("ld0_lat", 32'(lat), 32'(LAT));
        chk("ld0_data", 32'(rd), 32'hBEEF);

        do_req(1'b1, 1'b0, 16'h0005, 16'h1111, "iso_s0", rd, lat);
        do_req(1'b1, 1'b1, 16'h0005, 16'h2222, "iso_s1", rd, lat);
        do_req(1'b0, 1'b0, 16'h0005, 16'h0, "iso_l0", rd, lat);
        chk("iso_t0", 32'(rd), 32'h1111);
        do_req(1'b0, 1'b1, 16'h0005, 16'h0, "iso_l1", rd, lat);
        chk("iso_t1", 32'(rd), 32'h2222);

        b.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_rsp(1'b1, "bp", at);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) drive(1'b1, 1'b1, 1'b0, 16'h0009, 16'h3333);
            else        drive(1'b1, 1'b0, 1'b1, 16'h0007, 16'h0);
            if (i != 2) chk("bp_blocked", 32'(b.req_ready), 32'd0);
            chk("bp_rdata", 32'(b.rsp_rdata), 32'h2222);
            chk("bp_pend1", 32'(b.pending[1]), 32'd1);
            tick();
        end
        chk("bp_both", 32'(b.pending), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        b.rsp_ready = 1'b1;
        tick();
        wait_rsp(1'b0, "bp_t0", at);
        chk("bp_t0_data", 32'(b.rsp_rdata), 32'h3333);
        tick();

        b.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < LAT + 3; i++) tick();
        chk("ord_v1", 32'(b.rsp_valid), 32'd1);
        chk("ord_first", 32'(b.rsp_thread), 32'd1);
        chk("ord_d1", 32'(b.rsp_rdata), 32'h2222);
        b.rsp_ready = 1'b1;
        tick();
        chk("ord_v2", 32'(b.rsp_valid), 32'd1);
        chk("ord_second", 32'(b.rsp_thread), 32'd0);
        chk("ord_d2", 32'(b.rsp_rdata), 32'h1111);
        tick();

        drive(1'b1, 1'b1, 1'b0, 16'h0003, 16'h4444);
        tick();
        first = last_acc_cyc;
        drive(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0);
        chk("blk_ready", 32'(b.req_ready), 32'd0);
        for (int i = 0; i < 20 && last_acc_cyc == first; i++) tick();
        chk("blk_acc", 32'(last_acc_cyc), 32'(last_hs_cyc + 1));
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_rsp(1'b0, "blk", at);
        chk("blk_data", 32'(b.rsp_rdata), 32'h4444);
        tick();

        do_req(1'b1, 1'b0, 16'h0020, 16'hCAFE, "ar_st", rd, lat);
        drive(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 32'(b.rsp_valid), 32'd0);
        chk("ar_pending", 32'(b.pending), 32'd0);
        out[0] = 1'b0;
        out[1] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        do_req(1'b0, 1'b0, 16'h0020, 16'h0, "ar_ld", rd, lat);
        chk("ar_keep", 32'(rd), 32'hCAFE);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
                  16'($urandom));
            b.rsp_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        b.rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("drain", 32'(b.pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
